servo_ramp_ctrl: RTL and testbench
==================================

SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 10: control units moved per frame.
REQ-002 SHALL have parameter MAX_CTRL, default 2200: upper saturation limit of the control value.
REQ-003 SHALL have parameter HOLD_FRAMES, default 4: dwell frames after a ramp completes.
REQ-004 SHALL have port mclk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse from the PWM generator at period start, when its counter equals 0.
REQ-007 SHALL have port cmd_valid, input, 1: target request valid.
REQ-008 SHALL have port cmd_ready, output, 1: controller accepts a target this cycle.
REQ-009 SHALL have port cmd_pos, input, 12: requested target control value.
REQ-010 SHALL have port manual_en, input, 1: select manual jog mode.
REQ-011 SHALL have port manual_dir, input, 1: jog direction; 1 ramps toward MAX_CTRL, 0 ramps toward 0.
REQ-012 SHALL have port ctrl_out, output, 12: pulse-width offset driven to the PWM generator.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a commanded ramp reaches its target.
REQ-015 SHALL have port status, output, 16: {2'b01, 3'b000, ctrl_out[11:9], 2'b00, ctrl_out[8:4], dir}, where dir is the last step direction.

Function
REQ-016 SHALL implement an FSM with states IDLE, RAMP, HOLD and MANUAL.
REQ-017 SHALL drive cmd_ready = (state==IDLE) && !manual_en, so manual mode has priority over a simultaneous command.
REQ-018 SHALL, on cmd_valid && cmd_ready, latch target = min(cmd_pos, MAX_CTRL) and enter RAMP on the next cycle.
REQ-019 SHALL, in RAMP, update ctrl_out only on a frame_tick cycle: move by ±STEP toward target; if |target − ctrl_out| ≤ STEP, load target exactly (no overshoot).
REQ-020 SHALL, when ctrl_out equals target in RAMP (including when the accepted target equals ctrl_out), pulse done for 1 cycle and enter HOLD, or IDLE when SERVO_HOLD_EN is absent.
REQ-021 SHALL, in HOLD, count frame_ticks and return to IDLE on the HOLD_FRAMES-th tick.
REQ-022 SHALL ignore cmd_valid and manual_en in RAMP and HOLD.
REQ-023 SHALL enter MANUAL from IDLE when manual_en=1.
REQ-024 SHALL, in MANUAL, step ctrl_out by STEP on each frame_tick toward 0 or MAX_CTRL per manual_dir, saturating at both limits.
REQ-025 SHALL return from MANUAL to IDLE on the cycle after manual_en falls; done is not pulsed.
REQ-026 SHALL keep ctrl_out within 0..MAX_CTRL at all times, using 13-bit signed intermediate arithmetic.
REQ-027 SHALL update dir only on a cycle where ctrl_out changes.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, ctrl_out=0, target=0, hold counter=0, dir=0, done=0 and busy=0.
REQ-029 SHALL discard the target on reset during RAMP, HOLD or MANUAL; no done pulse.
REQ-030 SHALL not drive cmd_ready high in the cycle rst deasserts if manual_en=1.

Configuration
REQ-031 SHALL support macro SERVO_HOLD_EN: when defined, the HOLD state and hold counter exist; when undefined, HOLD is removed and RAMP goes to IDLE with done.

Structure
REQ-032 SHALL place in a shared package servo_pkg: the FSM state enum, the 12-bit control typedef and the default STEP/MAX_CTRL constants.
REQ-033 SHALL implement the step/saturate arithmetic as one sub-module, servo_step_calc (combinational: cur, goal, step -> next).

Verification
REQ-034 SHALL cover: reset, then cmd_pos=100 accepted -> ctrl_out 10,20,…,100 over 10 frame_ticks, done on the 10th, then busy low after 4 further ticks.
REQ-035 SHALL cover: ctrl_out=100, cmd_pos=95 -> ctrl_out=95 after 1 tick, no overshoot, dir=0.
REQ-036 SHALL cover: cmd_pos=4000 -> clamped, ramp stops at 2200, status=0x4000|(2200>>4 fields)|dir=1.
REQ-037 SHALL cover: IDLE, cmd_valid and manual_en both asserted -> cmd_ready=0, MANUAL entered; manual_dir=0 at ctrl_out=0 -> stays 0.
REQ-038 SHALL cover: rst pulsed mid-ramp at ctrl_out=50 -> ctrl_out=0 immediately (asynchronous), state IDLE, no done.
REQ-039 SHALL cover: build without SERVO_HOLD_EN, cmd_pos=20 -> done on the 2nd tick, busy low the next cycle.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo ramp controller.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_MANUAL
  } state_t;

  typedef logic [11:0] ctrl_t;

  localparam int DEF_STEP     = 10;
  localparam int DEF_MAX_CTRL = 2200;

endpackage

// File: rtl/servo_step_calc.sv
// Combinational step toward a goal: moves cur by at most step and never passes goal.
// The result is clamped to 0..MAX_CTRL using 13-bit signed intermediates.
module servo_step_calc
  import servo_pkg::*;
#(
  parameter int MAX_CTRL = DEF_MAX_CTRL
) (
  input  ctrl_t cur,
  input  ctrl_t goal,
  input  ctrl_t step,
  output ctrl_t next
);

  typedef logic signed [12:0] wide_t;

  function automatic ctrl_t sat(input wide_t v);
    if (v < 0) return '0;
    if (v > wide_t'(MAX_CTRL)) return ctrl_t'(MAX_CTRL);
    return ctrl_t'(v);
  endfunction

  wide_t cur_s;
  wide_t goal_s;
  wide_t step_s;
  wide_t diff;
  wide_t mag;

  always_comb begin
    cur_s  = $signed({1'b0, cur});
    goal_s = $signed({1'b0, goal});
    step_s = $signed({1'b0, step});
    diff   = goal_s - cur_s;
    mag    = (diff < 0) ? -diff : diff;
    // Within one step of the goal: land exactly on it rather than overshoot.
    if (mag <= step_s)
      next = sat(goal_s);
    else if (diff < 0)
      next = sat(cur_s - step_s);
    else
      next = sat(cur_s + step_s);
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Frame-paced servo ramp controller with commanded ramps and manual jog.
// Optional macro SERVO_HOLD_EN adds a HOLD dwell of HOLD_FRAMES ticks after each ramp.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int STEP        = DEF_STEP,
  parameter int MAX_CTRL    = DEF_MAX_CTRL,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_pos,
  input  logic        manual_en,
  input  logic        manual_dir,
  output logic [11:0] ctrl_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] status
);

  if (STEP < 1 || STEP > MAX_CTRL || MAX_CTRL > 4095 || HOLD_FRAMES < 1) begin : g_bad_params
    $error("servo_ramp_ctrl: invalid parameter set");
  end

  localparam ctrl_t MAX_C  = ctrl_t'(MAX_CTRL);
  localparam ctrl_t STEP_C = ctrl_t'(STEP);

  state_t state;
  ctrl_t  target;
  logic   dir;
  ctrl_t  goal;
  ctrl_t  step_next;
  ctrl_t  cmd_clamped;
  logic   ramp_hit;

`ifdef SERVO_HOLD_EN
  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_FRAMES - 1);
  logic [HCW-1:0] hold_cnt;
`endif

  assign cmd_clamped = (cmd_pos > MAX_C) ? MAX_C : cmd_pos;
  assign goal        = (state == ST_MANUAL) ? (manual_dir ? MAX_C : '0) : target;
  assign cmd_ready   = (state == ST_IDLE) && !manual_en;
  assign status      = {2'b01, 3'b000, ctrl_out[11:9], 2'b00, ctrl_out[8:4], dir};

  // Target reached either already (zero-length ramp) or by this tick's step.
  assign ramp_hit = (ctrl_out == target) || (frame_tick && (step_next == target));

  servo_step_calc #(
    .MAX_CTRL(MAX_CTRL)
  ) u_step (
    .cur (ctrl_out),
    .goal(goal),
    .step(STEP_C),
    .next(step_next)
  );

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ctrl_out <= '0;
      target   <= '0;
      dir      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef SERVO_HOLD_EN
      hold_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (manual_en) begin
            state <= ST_MANUAL;
            busy  <= 1'b1;
          end else if (cmd_valid) begin
            target <= cmd_clamped;
            state  <= ST_RAMP;
            busy   <= 1'b1;
          end
        end

        ST_RAMP: begin
          if (frame_tick && (ctrl_out != target)) begin
            ctrl_out <= step_next;
            dir      <= (step_next > ctrl_out);
          end
          if (ramp_hit) begin
            done <= 1'b1;
`ifdef SERVO_HOLD_EN
            state    <= ST_HOLD;
            hold_cnt <= '0;
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
          end
        end

`ifdef SERVO_HOLD_EN
        ST_HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
`endif

        ST_MANUAL: begin
          if (!manual_en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (frame_tick && (step_next != ctrl_out)) begin
            ctrl_out <= step_next;
            dir      <= (step_next > ctrl_out);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Table-driven bench for servo_ramp_ctrl with hand-written multi-cycle corner sequences.
module tb_servo_ramp_ctrl;

`ifdef SERVO_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_pos;
  logic        manual_en;
  logic        manual_dir;
  logic [11:0] ctrl_out;
  logic        busy;
  logic        done;
  logic [15:0] status;

  servo_ramp_ctrl dut (
    .mclk      (mclk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_pos   (cmd_pos),
    .manual_en (manual_en),
    .manual_dir(manual_dir),
    .ctrl_out  (ctrl_out),
    .busy      (busy),
    .done      (done),
    .status    (status)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic        tick;
    logic        valid;
    logic [11:0] pos;
    logic        men;
    logic        mdir;
    logic        rdy;
    logic [11:0] ctrl;
    logic        bsy;
    logic        dn;
    logic        dr;
  } vec_t;

  vec_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] spec_status(input logic [11:0] c, input logic d);
    return {2'b01, 3'b000, c[11:9], 2'b00, c[8:4], d};
  endfunction

  task automatic add(input logic t, input logic v, input logic [11:0] p, input logic me,
                     input logic md, input logic rdy, input logic [11:0] c, input logic b,
                     input logic d, input logic dr);
    vec_t e;
    e.tick = t; e.valid = v; e.pos = p; e.men = me; e.mdir = md;
    e.rdy = rdy; e.ctrl = c; e.bsy = b; e.dn = d; e.dr = dr;
    q.push_back(e);
  endtask

  // Dwell ticks; command and manual requests on the first one must be ignored.
  task automatic add_hold(input logic [11:0] c, input logic dr);
    if (HOLD)
      for (int i = 1; i <= 4; i++)
        add(1'b1, i == 1, 12'd700, i == 1, 1'b1, 1'b0, c, i < 4, 1'b0, dr);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge mclk);
      frame_tick = q[i].tick; cmd_valid = q[i].valid; cmd_pos = q[i].pos;
      manual_en = q[i].men; manual_dir = q[i].mdir;
      #1 chk($sformatf("%s%0d_ready", tag, i), cmd_ready, q[i].rdy);
      @(posedge mclk); #1;
      chk($sformatf("%s%0d_ctrl", tag, i), ctrl_out, q[i].ctrl);
      chk($sformatf("%s%0d_busy", tag, i), busy, q[i].bsy);
      chk($sformatf("%s%0d_done", tag, i), done, q[i].dn);
      chk($sformatf("%s%0d_status", tag, i), status, spec_status(q[i].ctrl, q[i].dr));
    end
    q.delete();
    @(negedge mclk);
    frame_tick = 0; cmd_valid = 0; cmd_pos = 0; manual_en = 0; manual_dir = 0;
  endtask

  task automatic tick_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk); frame_tick = 1;
      @(posedge mclk); #1;
    end
    @(negedge mclk); frame_tick = 0;
  endtask

  task automatic async_reset(input string tag);
    rst = 1;
    #1;
    chk({tag, "_ctrl"}, ctrl_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_status"}, status, 16'h4000);
    @(posedge mclk);
    @(negedge mclk); rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int maxv;
    logic got_done;
    logic saw_done;

    rst = 1; frame_tick = 0; cmd_valid = 0; cmd_pos = 0; manual_en = 0; manual_dir = 0;
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 16'h4000);
    chk("rst_ready", cmd_ready, 1);
    @(negedge mclk); rst = 0;

    // Zero-length ramp: target equals current value.
    add(0, 1, 12'd0, 0, 0, 1, 12'd0, 1, 0, 0);
    add(0, 0, 12'd0, 0, 0, 0, 12'd0, HOLD, 1, 0);
    add_hold(12'd0, 0);
    // Ramp 0 -> 100, with a command during RAMP ignored.
    add(0, 1, 12'd100, 0, 0, 1, 12'd0, 1, 0, 0);
    add(0, 1, 12'd500, 0, 0, 0, 12'd0, 1, 0, 0);
    for (int i = 1; i <= 10; i++)
      add(1, 0, 12'd0, 0, 0, 0, 12'(10 * i), (i < 10) || HOLD, i == 10, 1);
    add_hold(12'd100, 1);
    // 100 -> 95 in one tick without overshoot.
    add(0, 1, 12'd95, 0, 0, 1, 12'd100, 1, 0, 1);
    add(1, 0, 12'd0, 0, 0, 0, 12'd95, HOLD, 1, 0);
    add_hold(12'd95, 0);
    add(1, 0, 12'd0, 0, 0, 1, 12'd95, 0, 0, 0);
    run_table("ramp");

    // Clamped target 4000 -> 2200 from 95: 211 ticks.
    @(negedge mclk); cmd_valid = 1; cmd_pos = 12'd4000;
    #1 chk("clamp_ready", cmd_ready, 1);
    @(posedge mclk); #1;
    @(negedge mclk); cmd_valid = 0; cmd_pos = 0;
    ticks = 0; maxv = 0; got_done = 0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      @(negedge mclk); frame_tick = 1;
      @(posedge mclk); #1;
      ticks++;
      if (int'(ctrl_out) > maxv) maxv = int'(ctrl_out);
      got_done = done;
    end
    @(negedge mclk); frame_tick = 0;
    chk("clamp_done_seen", got_done, 1);
    chk("clamp_ticks", ticks, 211);
    chk("clamp_ctrl", ctrl_out, 2200);
    chk("clamp_max", maxv, 2200);
    chk("clamp_status", status, 16'h4413);
    chk("clamp_busy", busy, HOLD);
`ifdef SERVO_HOLD_EN
    tick_cycles(3);
    chk("clamp_hold3_busy", busy, 1);
    tick_cycles(1);
    chk("clamp_hold4_busy", busy, 0);
`endif

    async_reset("rst2");

    // Manual has priority over a simultaneous command; saturation at 0.
    add(0, 1, 12'd500, 1, 0, 0, 12'd0, 1, 0, 0);
    add(1, 0, 12'd0, 1, 0, 0, 12'd0, 1, 0, 0);
    add(1, 0, 12'd0, 1, 1, 0, 12'd10, 1, 0, 1);
    add(1, 0, 12'd0, 1, 1, 0, 12'd20, 1, 0, 1);
    add(0, 0, 12'd0, 1, 0, 0, 12'd20, 1, 0, 1);
    add(1, 0, 12'd0, 1, 0, 0, 12'd10, 1, 0, 0);
    add(0, 0, 12'd0, 0, 0, 0, 12'd10, 0, 0, 0);
    add(0, 0, 12'd0, 0, 0, 1, 12'd10, 0, 0, 0);
    run_table("man");

    // Manual jog up to MAX_CTRL and saturate there.
    @(negedge mclk); manual_en = 1; manual_dir = 1;
    @(posedge mclk); #1;
    ticks = 0; saw_done = 0;
    for (int i = 0; i < 300 && ctrl_out != 12'd2200; i++) begin
      @(negedge mclk); frame_tick = 1;
      @(posedge mclk); #1;
      ticks++;
      saw_done |= done;
    end
    chk("jog_ticks", ticks, 219);
    chk("jog_ctrl_max", ctrl_out, 2200);
    @(negedge mclk); frame_tick = 1;
    @(posedge mclk); #1;
    chk("jog_sat_ctrl", ctrl_out, 2200);
    chk("jog_sat_status", status, 16'h4413);
    @(negedge mclk); frame_tick = 0; manual_en = 0;
    @(posedge mclk); #1;
    saw_done |= done;
    chk("jog_exit_busy", busy, 0);
    chk("jog_no_done", saw_done, 0);

    // Reset in the middle of a ramp at ctrl_out = 50.
    async_reset("rst3");
    @(negedge mclk); cmd_valid = 1; cmd_pos = 12'd100;
    @(posedge mclk); #1;
    @(negedge mclk); cmd_valid = 0; cmd_pos = 0;
    tick_cycles(5);
    chk("mid_ctrl50", ctrl_out, 50);
    chk("mid_busy", busy, 1);
    @(posedge mclk); #3;
    rst = 1;
    #1;
    chk("mid_rst_ctrl", ctrl_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge mclk); rst = 0;
    #1 chk("mid_ready", cmd_ready, 1);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge mclk); frame_tick = 1;
      @(posedge mclk); #1;
      saw_done |= done;
    end
    @(negedge mclk); frame_tick = 0;
    chk("mid_after_done", saw_done, 0);
    chk("mid_after_ctrl", ctrl_out, 0);
    chk("mid_after_busy", busy, 0);

    // Reset released while manual_en is held high.
    rst = 1; manual_en = 1;
    @(posedge mclk);
    @(negedge mclk); rst = 0;
    #1 chk("rel_ready", cmd_ready, 0);
    @(posedge mclk); #1;
    chk("rel_busy_manual", busy, 1);
    @(negedge mclk); manual_en = 0;
    @(posedge mclk); #1;
    chk("rel_exit_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
